// File: rtl/key_expan.sv
// rtl/key_expan.sv - AES-128 key expansion into an 11-entry round-key table, one round key per clock.
// Optional: KEYEXP_RANGE_CHECK_EN forces round_key to zero for round values 11..15.
module key_expan (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [3:0]   round,
    input  logic [127:0] input_key,
    output logic [127:0] round_key,
    output logic         ready
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] key_table [0:10];
    logic [3:0]   cnt;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = {3'd0, ~b};
        return SBOX[{idx, 3'd0} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] step);
        case (step)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One AES-128 schedule step: the four output words chain through n0..n3.
    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        t  = {sub_byte(w3[23:16]) ^ rc, sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [3:0]   prev_idx;
    logic [127:0] next_key;

    always_comb begin
        prev_idx = cnt - 4'd1;
        next_key = expand(key_table[prev_idx], rcon(cnt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= 10; i++) key_table[i] <= '0;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == 4'd0) begin
            key_table[0] <= input_key;
            ready        <= 1'b0;
            cnt          <= 4'd1;
        end else if (cnt <= 4'd10) begin
            key_table[cnt] <= next_key;
            cnt            <= cnt + 4'd1;
            if (cnt == 4'd10) ready <= 1'b1;
        end
    end

    // Read index saturates at 10 so the table is never addressed out of range.
    logic [3:0] rd_idx;

    always_comb begin
        rd_idx = (round > 4'd10) ? 4'd10 : round;
`ifdef KEYEXP_RANGE_CHECK_EN
        round_key = (round > 4'd10) ? 128'h0 : key_table[rd_idx];
`else
        round_key = key_table[rd_idx];
`endif
    end

endmodule

// File: tb/tb_key_expan.sv
// tb/tb_key_expan.sv - scoreboard bench for key_expan against FIPS-197 key-schedule vectors.
module tb_key_expan;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [3:0]   round;
    logic [127:0] input_key;
    logic [127:0] round_key;
    logic         ready;

    key_expan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .round     (round),
        .input_key (input_key),
        .round_key (round_key),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] fips_a [0:10];
    logic [127:0] oor_a, oor_b;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] r, input logic [127:0] k);
        sb_entry_t e;
        e.rnd = r;
        e.key = k;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            round = e.rnd;
            #1;
            check($sformatf("rk%0d", e.rnd), round_key, e.key);
        end
        round = 4'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full 11-edge generation with latency checks on the first and last steps.
    task automatic generate_keys(input logic [127:0] key);
        round     = 4'd0;
        input_key = key;
        en        = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick(1);
            if (i == 1)  check("lat_rk0", round_key, key);
            if (i == 10) check("ready_edge10", {127'd0, ready}, 128'd0);
        end
        check("ready_edge11", {127'd0, ready}, 128'd1);
    endtask

    initial begin
        fips_a[0]  = KEY_A;
        fips_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef KEYEXP_RANGE_CHECK_EN
        oor_a = 128'h0;
        oor_b = 128'h0;
`else
        oor_a = fips_a[10];
        oor_b = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`endif

        rst_n = 1'b0; en = 1'b0; round = 4'd0; input_key = '0;
        #12;
        check("rst_ready", {127'd0, ready}, 128'd0);
        for (int r = 0; r < 16; r++) push(r[3:0], 128'h0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        input_key = KEY_A;
        tick(3);
        check("idle_ready", {127'd0, ready}, 128'd0);
        check("idle_rk0", round_key, 128'h0);

        // FIPS-197 Appendix A key, every round plus out-of-range reads.
        generate_keys(KEY_A);
        for (int r = 0; r <= 10; r++) push(r[3:0], fips_a[r]);
        push(4'd12, oor_a);
        push(4'd15, oor_a);
        drain();

        // Hold with en high: key changes after the sampling edge are ignored.
        en = 1'b0; tick(1);
        en = 1'b1; input_key = KEY_A; tick(1);
        input_key = KEY_B;
        tick(19);
        check("hold_ready", {127'd0, ready}, 128'd1);
        push(4'd0, fips_a[0]);
        push(4'd1, fips_a[1]);
        push(4'd10, fips_a[10]);
        drain();

        // Abort after 5 edges, then restart with the Appendix C.1 key.
        en = 1'b0; tick(1);
        en = 1'b1; input_key = KEY_B; tick(5);
        en = 1'b0; tick(1);
        check("abort_ready", {127'd0, ready}, 128'd0);
        push(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        push(4'd10, fips_a[10]);
        drain();
        generate_keys(KEY_B);
        push(4'd0, KEY_B);
        push(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        push(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        push(4'd12, oor_b);
        drain();

        // Asynchronous reset between edges 6 and 7 clears outputs at once.
        en = 1'b0; tick(1);
        en = 1'b1; input_key = KEY_A; tick(6);
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", {127'd0, ready}, 128'd0);
        check("async_rk0", round_key, 128'h0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        generate_keys(KEY_A);
        push(4'd2, fips_a[2]);
        push(4'd10, fips_a[10]);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
